audio_pwm_modulator: RTL
========================

// Module: audio_pwm_modulator
// PURPOSE
//  Consumer end of the audio pulsewidth stream: accepts BITRES-bit duty samples from the
//  waveform generators over a valid/ready handshake and drives the 1-bit speaker PWM pin.
//  Sits between the waveform/mixer stage and the board audio output.
//  Samples apply only on frame boundaries, so the output never glitches.
//  A soft-mute ramp steps the duty to/from the muted level instead of jumping to it.
// PARAMETERS
//  BITRES       `BITRES     duty resolution in bits; frame = 2**BITRES slots (default 4)
//  CLKDIV       16          clocks per slot; frame length = CLKDIV * 2**BITRES clocks
//  MUTED_LEVEL  `PWM_MUTED  idle/muted duty level (midscale, 8 at BITRES=4)
// PORTS
//  clk          in   1       system clock (100 MHz)
//  resetn       in   1       synchronous active-low reset
//  mute         in   1       soft-mute request, level sensitive
//  in_valid     in   1       in_pw holds a sample
//  in_pw        in   BITRES  duty sample, 0..2**BITRES-1
//  in_ready     out  1       holding register empty; sample accepted when in_valid & in_ready
//  pwm_out      out  1       PWM output to speaker pin, registered
//  frame_start  out  1       1-clk pulse on the first clock of each frame
//  underrun     out  1       1-clk pulse: RUN-state frame started with no pending sample
//  muted        out  1       high while FSM is in MUTED
// BEHAVIOUR
//  Reset (resetn=0 at a clk edge):
//   pwm_out=0, frame_start=0, underrun=0, muted=1, in_ready=1.
//   level=target=MUTED_LEVEL; FSM=MUTED; divider and slot counters=0; pending empty.
//  Timing:
//   - div counts 0..CLKDIV-1; slot increments when div wraps; slot wraps 2**BITRES-1 -> 0.
//   - Frame boundary (fb) = div==CLKDIV-1 && slot==2**BITRES-1. frame_start asserts the
//     clock after fb.
//   - pwm_out <= (slot < level), registered; one clock behind the counters.
//     level=0: constantly 0. level=N: high N*CLKDIV clocks per frame.
//  Handshake:
//   - One-entry holding register (pending). in_ready = ~pending_full.
//   - At fb, a full pending register moves into target and empties.
//   - A handshake on the fb cycle fills pending for the NEXT frame; no bypass.
//     If pending was empty at that fb, it counts as an underrun.
//   - in_pw is not sampled when in_ready=0.
//  FSM (evaluated only at fb, after the target update; level changes only at fb):
//   - MUTED:    level=MUTED_LEVEL. If ~mute -> FADE_IN.
//               Pending is still drained into target, so upstream never stalls.
//   - FADE_IN:  level steps +/-1 toward target. On reaching target -> RUN.
//               mute=1 -> FADE_OUT, from the current level.
//   - RUN:      level=target. mute=1 -> FADE_OUT.
//               Empty pending at fb -> underrun pulse; level holds the last value.
//   - FADE_OUT: level steps +/-1 toward MUTED_LEVEL. On reaching it -> MUTED.
//               mute=0 -> FADE_IN.
//   - A ramp whose start value already equals its goal completes in the same fb.
//  Widths:
//   - level/target are BITRES bits; the ramp never over/underflows, since every
//     step is toward a value inside range.
//  Timing of pulses and status:
//   - underrun pulses the clock after fb, aligned with frame_start.
//   - muted follows the FSM state register.
//   - mute changes between boundaries take effect at the next fb.
//  Reset mid-frame: all state returns to reset values on the next edge with resetn=0.
//   No partial frame is completed.
// TESTING (BITRES=4, CLKDIV=16, MUTED_LEVEL=8; frame=256 clk)
//  1. Reset, mute=0, no samples:
//     -> muted=1; at first fb FSM goes to FADE_IN; target=8 so it is reached at once.
//     -> RUN; pwm_out high 128 of every 256 clocks; underrun each frame.
//  2. In RUN, send in_pw=12 mid-frame:
//     -> in_ready low until the next fb; following frame pwm_out high 192/256; no underrun.
//  3. Send 0 then 15 on consecutive frames:
//     -> pwm_out constant 0 for one frame, then high 240/256; frame_start every 256 clocks.
//  4. level=12, raise mute:
//     -> duty 11,10,9,8 over 4 frames (high 176,160,144,128 clocks); then muted=1.
//     -> Drop mute after 2 frames instead -> ramp reverses back to 12 (FADE_IN->RUN).
//  5. Keep in_valid=1 with a fresh sample every frame:
//     -> exactly one accept per frame, no underrun.
//     -> Assert in_valid exactly on the fb cycle with pending empty
//        -> underrun=1, and the sample appears one frame later.
//  6. Assert resetn=0 mid-frame with level=15:
//     -> next clock pwm_out=0, counters=0, muted=1, in_ready=1.

Source files
------------

// File: rtl/audio_pwm_modulator.sv
// ---------------------------------------------------------------------------
// audio_pwm_modulator
//   Consumer end of the audio pulse-width stream. Duty samples arrive over a
//   valid/ready handshake into a one-entry holding register. At each frame
//   boundary a held sample becomes the new target duty. A soft-mute ramp moves
//   the applied level one step per frame toward the target or toward the muted
//   midscale level. Output changes only on frame boundaries, so the pin never
//   glitches.
//
// Ports
//   clk          in   system clock
//   resetn       in   synchronous active-low reset
//   mute         in   soft-mute request, level sensitive, acted on at frame boundary
//   in_valid     in   in_pw holds a sample
//   in_pw        in   duty sample, 0 .. 2**BITRES-1
//   in_ready     out  holding register empty
//   pwm_out      out  registered PWM pin, high while slot < level
//   frame_start  out  1-clk pulse on the first clock of each frame
//   underrun     out  1-clk pulse: frame started in RUN with no pending sample
//   muted        out  high while the FSM is in MUTED
// ---------------------------------------------------------------------------
module audio_pwm_modulator #(
  parameter int BITRES      = 4,
  parameter int CLKDIV      = 16,
  parameter int MUTED_LEVEL = 1 << (BITRES - 1)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              mute,
  input  logic              in_valid,
  input  logic [BITRES-1:0] in_pw,
  output logic              in_ready,
  output logic              pwm_out,
  output logic              frame_start,
  output logic              underrun,
  output logic              muted
);

  localparam int DIV_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLKDIV - 1);
  localparam logic [BITRES-1:0] SLOT_LAST  = {BITRES{1'b1}};
  localparam logic [BITRES-1:0] LVL_MUTED  = BITRES'(MUTED_LEVEL);

  typedef enum logic [1:0] {
    ST_MUTED    = 2'd0,
    ST_FADE_IN  = 2'd1,
    ST_RUN      = 2'd2,
    ST_FADE_OUT = 2'd3
  } state_e;

  // One ramp step: move by one toward goal, or stay if already there.
  function automatic logic [BITRES-1:0] step_toward(input logic [BITRES-1:0] cur,
                                                    input logic [BITRES-1:0] goal);
    logic [BITRES-1:0] res;
    if (cur < goal) begin
      res = cur + BITRES'(1);
    end else if (cur > goal) begin
      res = cur - BITRES'(1);
    end else begin
      res = cur;
    end
    return res;
  endfunction

  logic [DIV_W-1:0]  div_q,       div_d;
  logic [BITRES-1:0] slot_q,      slot_d;
  logic [BITRES-1:0] level_q,     level_d;
  logic [BITRES-1:0] target_q,    target_d;
  logic [BITRES-1:0] pend_q,      pend_d;
  logic              pend_full_q, pend_full_d;
  state_e            state_q,     state_d;
  logic              pwm_q;
  logic              frame_start_q;
  logic              underrun_q;
  logic              muted_q;

  logic fb_s;
  logic accept_s;
  logic [BITRES-1:0] ramp_s;

  assign fb_s     = (div_q == DIV_LAST) && (slot_q == SLOT_LAST);
  assign accept_s = in_valid && !pend_full_q;

  // Divider and slot counters; slot advances when the divider wraps.
  always_comb begin
    div_d  = div_q;
    slot_d = slot_q;
    if (div_q == DIV_LAST) begin
      div_d  = '0;
      slot_d = slot_q + BITRES'(1);
    end else begin
      div_d  = div_q + DIV_W'(1);
    end
  end

  // Holding register. A boundary drains it into target; a handshake on the
  // boundary cycle itself can only happen when it was already empty, so it
  // refills for the following frame with no bypass into target.
  always_comb begin
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    target_d    = target_q;
    if (fb_s && pend_full_q) begin
      target_d    = pend_q;
      pend_full_d = 1'b0;
    end else begin
      target_d    = target_q;
    end
    if (accept_s) begin
      pend_d      = in_pw;
      pend_full_d = 1'b1;
    end else begin
      pend_d      = pend_q;
    end
  end

  // Mute/ramp FSM, evaluated only on frame boundaries against the updated target.
  // Entering a ramp takes its first step in the same boundary, so a ramp whose
  // start equals its goal completes immediately.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    ramp_s  = level_q;
    if (fb_s) begin
      case (state_q)
        ST_MUTED: begin
          if (!mute) begin
            ramp_s  = step_toward(LVL_MUTED, target_d);
            level_d = ramp_s;
            state_d = (ramp_s == target_d) ? ST_RUN : ST_FADE_IN;
          end else begin
            level_d = LVL_MUTED;
          end
        end
        ST_FADE_IN, ST_FADE_OUT: begin
          if (mute) begin
            ramp_s  = step_toward(level_q, LVL_MUTED);
            level_d = ramp_s;
            state_d = (ramp_s == LVL_MUTED) ? ST_MUTED : ST_FADE_OUT;
          end else begin
            ramp_s  = step_toward(level_q, target_d);
            level_d = ramp_s;
            state_d = (ramp_s == target_d) ? ST_RUN : ST_FADE_IN;
          end
        end
        ST_RUN: begin
          if (mute) begin
            ramp_s  = step_toward(level_q, LVL_MUTED);
            level_d = ramp_s;
            state_d = (ramp_s == LVL_MUTED) ? ST_MUTED : ST_FADE_OUT;
          end else begin
            level_d = target_d;
          end
        end
        default: begin
          state_d = ST_MUTED;
          level_d = LVL_MUTED;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      div_q         <= '0;
      slot_q        <= '0;
      level_q       <= LVL_MUTED;
      target_q      <= LVL_MUTED;
      pend_q        <= '0;
      pend_full_q   <= 1'b0;
      state_q       <= ST_MUTED;
      pwm_q         <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      muted_q       <= 1'b1;
    end else begin
      div_q         <= div_d;
      slot_q        <= slot_d;
      level_q       <= level_d;
      target_q      <= target_d;
      pend_q        <= pend_d;
      pend_full_q   <= pend_full_d;
      state_q       <= state_d;
      // Compare uses the current counters, so the pin trails them by one clock
      // and the new level lines up with slot 0 on the frame_start clock.
      pwm_q         <= (slot_q < level_q);
      frame_start_q <= fb_s;
      underrun_q    <= fb_s && (state_q == ST_RUN) && !pend_full_q;
      muted_q       <= (state_d == ST_MUTED);
    end
  end

  assign in_ready    = !pend_full_q;
  assign pwm_out     = pwm_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;
  assign muted       = muted_q;

endmodule
